// File: rtl/systolic_result_drain.sv
// Result drain for the ternary systolic array: snapshots the accumulator
// matrix, requantizes each element (arithmetic shift + saturation) and
// streams it out row-major over a valid/ready interface.
module systolic_result_drain #(
  parameter int WIDTH          = 16,
  parameter int HIDDEN_SIZE    = 2,
  parameter int CONTEXT_LENGTH = 4,
  parameter int OUT_WIDTH      = 16,
  parameter int SHIFT          = 0,
  localparam int ACC_W = 2 * WIDTH,
  localparam int ROW_W = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1,
  localparam int COL_W = (CONTEXT_LENGTH > 1) ? $clog2(CONTEXT_LENGTH) : 1,
  localparam int CNT_W = $clog2(HIDDEN_SIZE * CONTEXT_LENGTH + 1)
) (
  input  logic                                                      clock,
  input  logic                                                      rst,
  input  logic signed [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][ACC_W-1:0] y_in,
  input  logic                                                      y_valid,
  output logic                                                      y_ready,
  output logic                                                      m_valid,
  input  logic                                                      m_ready,
  output logic signed [OUT_WIDTH-1:0]                               m_data,
  output logic        [ROW_W-1:0]                                   m_row,
  output logic        [COL_W-1:0]                                   m_col,
  output logic                                                      m_last,
  output logic                                                      m_sat,
  output logic        [CNT_W-1:0]                                   sat_count
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'({(OUT_WIDTH-1){1'b1}});
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  state_t                                           state, state_nxt;
  logic [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][ACC_W-1:0] snap;
  logic [ROW_W-1:0]                                 row;
  logic [COL_W-1:0]                                 col;
  logic                                             at_row_end, at_col_end;
  logic                                             fire, capture;
  logic signed [ACC_W-1:0]                          elem;
  logic [OUT_WIDTH:0]                               rq;

  // Returns {saturated, requantized value}.
  function automatic logic [OUT_WIDTH:0] requant(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] v;
    v = x >>> SHIFT;
    if (v > MAX_V)      requant = {1'b1, MAX_V[OUT_WIDTH-1:0]};
    else if (v < MIN_V) requant = {1'b1, MIN_V[OUT_WIDTH-1:0]};
    else                requant = {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  // Outputs depend only on registered state, never on m_ready/y_valid.
  assign elem       = $signed(snap[row][col]);
  assign rq         = requant(elem);
  assign m_data     = rq[OUT_WIDTH-1:0];
  assign m_sat      = rq[OUT_WIDTH];
  assign m_row      = row;
  assign m_col      = col;
  assign at_row_end = (row == ROW_W'(HIDDEN_SIZE - 1));
  assign at_col_end = (col == COL_W'(CONTEXT_LENGTH - 1));
  assign m_valid    = (state == DRAIN);
  assign m_last     = m_valid && at_row_end && at_col_end;
  // y_ready is held low while reset is asserted.
  assign y_ready    = (state == IDLE) && rst;
  assign fire       = m_valid && m_ready;
  assign capture    = y_valid && y_ready;

  // Next-state logic: capture starts a drain, the last transfer ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = DRAIN;
      DRAIN:   if (fire && m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Snapshot of the accumulator matrix, taken on capture.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)         snap <= '0;
    else if (capture) snap <= y_in;
  end

  // Row-major element index and per-matrix saturation count.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      row       <= '0;
      col       <= '0;
      sat_count <= '0;
    end else if (capture) begin
      row       <= '0;
      col       <= '0;
      sat_count <= '0;
    end else if (fire) begin
      sat_count <= sat_count + CNT_W'(m_sat);
      if (m_last) begin
        row <= '0;
        col <= '0;
      end else if (at_col_end) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule
